// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline; control outputs are combinational (0-cycle latency).
// Backpressure: dmem/imem waits and load-use hazards hold or bubble the upstream pipeline registers.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_ren,
  input  logic             id_rs2_ren,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             redirect_take,
  output logic             if_id_valid,
  output logic             if_id_flush,
  output logic             id_ex_valid,
  output logic             id_ex_flush,
  output logic             ex_mem_valid,
  output logic             ex_mem_flush,
  output logic             mem_wb_valid,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] ERROR     = 2'd2;

  localparam logic [15:0]      TIMEOUT_W = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]  fsm;
  logic [15:0] wait_cnt;
  logic        drop_pending;

  logic dmem_stall;
  logic load_use;
  logic take_redirect;
  logic take_drop;

  assign dmem_stall = !dmem_ready && ((fsm == RUN && mem_req) || fsm == DMEM_WAIT);
  assign load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_ren && id_rs1 == ex_rd) || (id_rs2_ren && id_rs2 == ex_rd));

  // Rule decisions that also feed state updates; ERROR and dmem stall mask everything below.
  assign take_redirect = reset && (fsm != ERROR) && !dmem_stall && ex_redirect;
  assign take_drop     = reset && (fsm != ERROR) && !dmem_stall && !ex_redirect &&
                         !load_use && drop_pending && imem_ready;

  always_comb begin
    pc_en         = 1'b0;
    redirect_take = 1'b0;
    if_id_valid   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_valid   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_valid  = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_valid  = 1'b0;
    mem_wb_flush  = 1'b0;
    if (!reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (fsm == ERROR || dmem_stall) begin
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      redirect_take = 1'b1;
      pc_en         = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_valid  = 1'b1;
      mem_wb_valid  = 1'b1;
    end else if (load_use) begin
      id_ex_flush  = 1'b1;
      ex_mem_valid = 1'b1;
      mem_wb_valid = 1'b1;
    end else if (take_drop || !imem_ready) begin
      if_id_flush  = 1'b1;
      id_ex_valid  = 1'b1;
      ex_mem_valid = 1'b1;
      mem_wb_valid = 1'b1;
    end else begin
      pc_en        = 1'b1;
      if_id_valid  = 1'b1;
      id_ex_valid  = 1'b1;
      ex_mem_valid = 1'b1;
      mem_wb_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm             <= RUN;
      wait_cnt        <= 16'd0;
      mem_timeout_err <= 1'b0;
    end else begin
      case (fsm)
        RUN: begin
          if (mem_req && !dmem_ready) begin
            fsm      <= DMEM_WAIT;
            wait_cnt <= 16'd1;
          end
        end
        DMEM_WAIT: begin
          if (dmem_ready) begin
            fsm      <= RUN;
            wait_cnt <= 16'd0;
          end else if (wait_cnt == TIMEOUT_W) begin
            fsm             <= ERROR;
            mem_timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: fsm <= ERROR;
      endcase
    end
  end

  // A redirect during an outstanding fetch leaves a stale instruction in flight to discard.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_pending <= 1'b0;
    end else if (take_redirect && !imem_ready) begin
      drop_pending <= 1'b1;
    end else if (take_drop) begin
      drop_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (fsm != ERROR && !pc_en && stall_cycles != CNT_MAX) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if (redirect_take && flush_events != CNT_MAX) begin
        flush_events <= flush_events + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: rule-table reference model checked every cycle plus directed literal checks.
module tb_pipeline_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int SATV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_rs1_ren, id_rs2_ren, ex_mem_read, ex_redirect;
  logic          mem_req, dmem_ready, imem_ready;
  logic          pc_en, redirect_take;
  logic          if_id_valid, if_id_flush, id_ex_valid, id_ex_flush;
  logic          ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush;
  logic          mem_timeout_err;
  logic [CW-1:0] stall_cycles, flush_events;

  int total = 0;
  int passed = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_en(pc_en), .redirect_take(redirect_take),
    .if_id_valid(if_id_valid), .if_id_flush(if_id_flush),
    .id_ex_valid(id_ex_valid), .id_ex_flush(id_ex_flush),
    .ex_mem_valid(ex_mem_valid), .ex_mem_flush(ex_mem_flush),
    .mem_wb_valid(mem_wb_valid), .mem_wb_flush(mem_wb_flush),
    .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: which priority rule applies, and the stage action each rule implies.
  // Vector order: pc_en, redirect_take, then (valid, flush) for if_id, id_ex, ex_mem, mem_wb.
  localparam int R_RESET = 0, R_HALT = 1, R_REDIR = 2, R_LU = 3, R_DROP = 4, R_ISTALL = 5, R_NORM = 6;
  logic [9:0] act_tbl [7] = '{10'b00_01_01_01_01, 10'b00_00_00_00_01, 10'b11_01_01_10_10,
                              10'b00_00_01_10_10, 10'b00_01_10_10_10, 10'b00_01_10_10_10,
                              10'b10_10_10_10_10};
  int m_st = 0, m_w = 0, m_stall = 0, m_flush = 0;
  bit m_drop = 0, m_err = 0;

  function automatic int pick_rule();
    bit hz;
    hz = ex_mem_read && ex_rd != 0 &&
         ((id_rs1_ren && id_rs1 == ex_rd) || (id_rs2_ren && id_rs2 == ex_rd));
    if (!reset) return R_RESET;
    if (m_st == 2) return R_HALT;
    if (!dmem_ready && (m_st == 1 || mem_req)) return R_HALT;
    if (ex_redirect) return R_REDIR;
    if (hz) return R_LU;
    if (m_drop && imem_ready) return R_DROP;
    if (!imem_ready) return R_ISTALL;
    return R_NORM;
  endfunction

  always @(negedge clk) begin
    int r;
    logic [9:0] exp_v;
    r = pick_rule();
    exp_v = act_tbl[r];
    chk("ctrl_outputs", 32'({pc_en, redirect_take, if_id_valid, if_id_flush, id_ex_valid,
                             id_ex_flush, ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush}),
        32'(exp_v));
    chk("model_stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("model_flush_events", 32'(flush_events), 32'(m_flush));
    chk("model_timeout_err", 32'(mem_timeout_err), 32'(m_err));
    // advance the model with the inputs that will be sampled at the next rising edge
    if (!reset) begin
      m_st = 0; m_w = 0; m_drop = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_st != 2 && exp_v[9] == 1'b0 && m_stall < SATV) m_stall++;
      if (r == R_REDIR && m_flush < SATV) m_flush++;
      if (r == R_REDIR && !imem_ready) m_drop = 1;
      else if (r == R_DROP) m_drop = 0;
      if (m_st == 0 && mem_req && !dmem_ready) begin
        m_st = 1; m_w = 1;
      end else if (m_st == 1) begin
        if (dmem_ready) begin m_st = 0; m_w = 0; end
        else if (m_w == TO) begin m_st = 2; m_err = 1; end
        else m_w++;
      end
    end
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_rs1_ren = 0; id_rs2_ren = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_req = 0; dmem_ready = 0; imem_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_ren = 1;
  endtask

  initial begin
    reset = 0;
    idle();
    smp();
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_if_id_flush", 32'(if_id_flush), 1);
    chk("rst_mem_wb_flush", 32'(mem_wb_flush), 1);
    chk("rst_stall_cnt", 32'(stall_cycles), 0);
    tick();
    reset = 1;
    smp();
    chk("idle_pc_en", 32'(pc_en), 1);
    tick();

    // load-use on rs1
    set_lu();
    smp();
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_if_id_valid", 32'(if_id_valid), 0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
    chk("lu_ex_mem_valid", 32'(ex_mem_valid), 1);
    tick();
    chk("lu_stall_cnt", 32'(stall_cycles), 1);

    // x0 destination and non-reading source do not stall
    ex_rd = 0; id_rs1 = 0;
    smp();
    chk("x0_pc_en", 32'(pc_en), 1);
    chk("x0_id_ex_flush", 32'(id_ex_flush), 0);
    tick();
    ex_rd = 5; id_rs1 = 5; id_rs1_ren = 0;
    smp();
    chk("noren_pc_en", 32'(pc_en), 1);
    tick();
    id_rs2 = 5; id_rs2_ren = 1;
    smp();
    chk("lu_rs2_pc_en", 32'(pc_en), 0);
    tick();
    chk("lu_rs2_stall_cnt", 32'(stall_cycles), 2);

    // redirect overrides load-use
    idle(); set_lu(); ex_redirect = 1;
    smp();
    chk("redir_take", 32'(redirect_take), 1);
    chk("redir_pc_en", 32'(pc_en), 1);
    chk("redir_if_id_flush", 32'(if_id_flush), 1);
    chk("redir_id_ex_flush", 32'(id_ex_flush), 1);
    tick();
    chk("redir_flush_cnt", 32'(flush_events), 1);

    // dmem wait for 3 cycles with a redirect held pending
    idle(); mem_req = 1; dmem_ready = 0; ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("dw_pc_en", 32'(pc_en), 0);
      chk("dw_mem_wb_flush", 32'(mem_wb_flush), 1);
      chk("dw_redir_ignored", 32'(redirect_take), 0);
      chk("dw_if_id_hold", 32'({if_id_valid, if_id_flush}), 0);
      tick();
    end
    dmem_ready = 1;
    smp();
    chk("dw_release_redir", 32'(redirect_take), 1);
    tick();
    chk("dw_stall_cnt", 32'(stall_cycles), 5);
    chk("dw_flush_cnt", 32'(flush_events), 2);
    idle();
    smp();
    chk("dw_back_to_run", 32'(pc_en), 1);
    tick();

    // redirect while a fetch is outstanding, then the stale fetch is dropped
    ex_redirect = 1; imem_ready = 0;
    smp();
    chk("drop_redir_pc_en", 32'(pc_en), 1);
    tick();
    ex_redirect = 0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("drop_istall_flush", 32'(if_id_flush), 1);
      chk("drop_istall_pc_en", 32'(pc_en), 0);
      tick();
    end
    imem_ready = 1;
    smp();
    chk("drop_cycle_flush", 32'(if_id_flush), 1);
    chk("drop_cycle_pc_en", 32'(pc_en), 0);
    tick();
    smp();
    chk("drop_after_pc_en", 32'(pc_en), 1);
    chk("drop_after_flush", 32'(if_id_flush), 0);
    tick();
    chk("drop_stall_cnt", 32'(stall_cycles), 8);
    chk("drop_flush_cnt", 32'(flush_events), 3);

    // counters saturate instead of wrapping
    imem_ready = 0;
    repeat (10) tick();
    chk("sat_stall_cnt", 32'(stall_cycles), 15);
    idle(); ex_redirect = 1;
    repeat (13) tick();
    chk("sat_flush_cnt", 32'(flush_events), 15);

    // dmem timeout into ERROR, sticky until reset
    idle(); mem_req = 1; dmem_ready = 0;
    repeat (4) tick();
    chk("to_not_yet", 32'(mem_timeout_err), 0);
    tick();
    chk("to_err_set", 32'(mem_timeout_err), 1);
    mem_req = 0; dmem_ready = 1; ex_redirect = 1;
    smp();
    chk("err_pc_en", 32'(pc_en), 0);
    chk("err_redir", 32'(redirect_take), 0);
    chk("err_mem_wb_flush", 32'(mem_wb_flush), 1);
    tick();
    chk("err_sticky", 32'(mem_timeout_err), 1);
    reset = 0;
    smp();
    chk("rst2_if_id_flush", 32'(if_id_flush), 1);
    tick();
    reset = 1; idle();
    smp();
    chk("rst2_err", 32'(mem_timeout_err), 0);
    chk("rst2_stall_cnt", 32'(stall_cycles), 0);
    chk("rst2_flush_cnt", 32'(flush_events), 0);
    chk("rst2_run_pc_en", 32'(pc_en), 1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the valid (hold/advance) and flush (bubble) inputs of the if_id, id_ex, ex_mem and mem_wb pipeline registers, and drives the PC enable and redirect select.
- Handles load-use hazards, EX-resolved redirects, instruction-memory wait and data-memory wait.
- A data-memory timeout FSM and saturating performance counters are included.

Parameters:
- MEM_TIMEOUT, 255, number of consecutive DMEM_WAIT cycles with dmem_ready low before entering ERROR (legal range 2..65535).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_rs1_ren  in  1  ID instruction reads rs1.
- id_rs2_ren  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  EX-stage instruction is a load (id_ex mem_read output).
- ex_rd  in  5  EX-stage destination register.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction memory returns the fetch this cycle.
- pc_en  out  1  PC register update enable.
- redirect_take  out  1  PC mux selects the EX target.
- if_id_valid  out  1  if_id register advance enable.
- if_id_flush  out  1  if_id register bubble insert.
- id_ex_valid  out  1  id_ex register advance enable.
- id_ex_flush  out  1  id_ex register bubble insert.
- ex_mem_valid  out  1  ex_mem register advance enable.
- ex_mem_flush  out  1  ex_mem register bubble insert.
- mem_wb_valid  out  1  mem_wb register advance enable.
- mem_wb_flush  out  1  mem_wb register bubble insert.
- mem_timeout_err  out  1  sticky data-memory timeout flag.
- stall_cycles  out  CNT_W  count of stall cycles.
- flush_events  out  CNT_W  count of taken redirects.

Behaviour:
- Registered state: fsm (RUN, DMEM_WAIT, ERROR), wait_cnt (16 bit), drop_pending, mem_timeout_err, and both counters.
- Control outputs are combinational from state and inputs, with zero-cycle latency.
- Action names used below:
  - "advance": valid=1, flush=0.
  - "hold": valid=0, flush=0.
  - "bubble": flush=1, valid=0.
- Reset (reset==0 at the clock edge):
  - fsm=RUN; wait_cnt, drop_pending, mem_timeout_err, stall_cycles and flush_events all 0.
  - While reset is low, outputs are forced: pc_en=0, redirect_take=0, all valid=0, all flush=1.
  - Reset asserted mid-wait or in ERROR returns cleanly to RUN.
- Priority each cycle, highest first:
  1. ERROR state: pc_en=0; if_id, id_ex and ex_mem hold; mem_wb bubble; redirect_take=0.
  2. dmem stall, i.e. (RUN and mem_req and !dmem_ready) or (DMEM_WAIT and !dmem_ready):
     - pc_en=0; if_id, id_ex and ex_mem hold; mem_wb bubble.
     - ex_redirect is ignored. EX is held, so the redirect is re-presented after release.
  3. Redirect (ex_redirect):
     - redirect_take=1, pc_en=1.
     - if_id bubble, id_ex bubble; ex_mem and mem_wb advance.
     - Overrides load-use and imem stall.
     - If imem_ready==0 this cycle, set drop_pending.
  4. Load-use, i.e. ex_mem_read and ex_rd!=0 and ((id_rs1_ren and id_rs1==ex_rd) or (id_rs2_ren and id_rs2==ex_rd)):
     - pc_en=0; if_id hold; id_ex bubble; ex_mem and mem_wb advance.
  5. Drop cycle (drop_pending and imem_ready):
     - pc_en=0; if_id bubble; others advance.
     - Clear drop_pending.
  6. imem stall (!imem_ready): pc_en=0; if_id bubble; others advance.
  7. Normal: pc_en=1; all stages advance.
- FSM transitions:
  - RUN to DMEM_WAIT when mem_req and !dmem_ready; wait_cnt becomes 1.
  - DMEM_WAIT with !dmem_ready: wait_cnt increments.
  - DMEM_WAIT to ERROR when wait_cnt==MEM_TIMEOUT and !dmem_ready; mem_timeout_err is set.
  - DMEM_WAIT with dmem_ready: the cycle is a normal release evaluated through rules 3–7; next state RUN, wait_cnt=0.
  - RUN with mem_req and dmem_ready: single-cycle access, no stall.
  - ERROR is left only by reset.
- Counters (both saturate at all-ones, no wrap):
  - stall_cycles increments every non-reset cycle in RUN or DMEM_WAIT with pc_en==0.
  - flush_events increments on every cycle in which redirect_take==1.
- The controller never asserts valid and flush together for the same register.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_ren=1 for 1 cycle -> pc_en=0, if_id_valid=0, id_ex_flush=1, ex_mem_valid=1, stall_cycles 0->1.
- x0 and non-read cases: same as the load-use test but with ex_rd=0, or with id_rs1_ren=0 -> normal advance, pc_en=1, no flush.
- Redirect plus load-use together: ex_redirect=1 with a load-use match -> redirect_take=1, pc_en=1, if_id_flush=1, id_ex_flush=1, flush_events=1.
- dmem wait: mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 cycles with pc_en=0, mem_wb_flush=1, upstream hold; ex_redirect held high during the wait is ignored, then taken on the release cycle; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, mem_req=1, dmem_ready=0 indefinitely -> ERROR after 4 DMEM_WAIT cycles, mem_timeout_err=1 sticky; reset low for 1 cycle -> err=0, state RUN, counters 0.
- Dropped fetch: ex_redirect=1 with imem_ready=0, then imem_ready=0 for 2 cycles, then 1 -> redirect cycle has pc_en=1; 2 imem-stall cycles with if_id_flush=1; drop cycle has if_id_flush=1 and pc_en=0; the following cycle is normal.
